// File: rtl/blob_frame_sequencer.sv
// Frame-level sequencer between the binarized pixel stream and the blob-counting core.
// Aligns to SOF, feeds one frame with a one-cycle valid lead, collects the count, aborts on faults.
module blob_frame_sequencer #(
    parameter int IMG_COL = 640,
    parameter int IMG_ROW = 480,
    parameter int TIMEOUT = 4096,
    parameter int RST_CYC = 4,
    parameter int CNT_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_cont,
    input  logic             i_stop,
    input  logic             i_pix_valid,
    input  logic             i_pix_sof,
    input  logic             i_pix_bin,
    output logic             o_core_rst_n,
    output logic             o_core_valid,
    output logic             o_core_seq,
    input  logic             i_core_valid,
    input  logic [CNT_W-1:0] i_core_count,
    output logic [CNT_W-1:0] o_count,
    output logic             o_count_valid,
    output logic             o_busy,
    output logic             o_err,
    output logic [1:0]       o_err_code,
    output logic [15:0]      o_frame_cnt,
    output logic [2:0]       o_dbg_state
);
    localparam int NPIX  = IMG_COL * IMG_ROW;
    localparam int PIX_W = $clog2(NPIX + 1);
    localparam int TMR_W = ($clog2(TIMEOUT + 1) > 12) ? $clog2(TIMEOUT + 1) : 12;
    localparam int RST_W = $clog2(RST_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_STREAM, S_WAIT_RES, S_RELEASE, S_ABORT
    } state_t;

    state_t             r_state, w_next;
    logic [PIX_W-1:0]   r_pix_cnt;
    logic [TMR_W-1:0]   r_timer;
    logic [RST_W-1:0]   r_hold, w_hold_next;
    logic               r_core_rst_n, r_core_valid, r_core_valid_q;
    logic               r_d1, r_seq, r_cont, r_stop_pend;
    logic [CNT_W-1:0]   r_count;
    logic               r_count_valid, r_err;
    logic [1:0]         r_err_code, w_abort_code;
    logic [15:0]        r_frame_cnt;
    logic               w_beat, w_result, w_stop_any, w_core_rise;

    assign w_stop_any  = r_stop_pend | i_stop;
    assign w_core_rise = i_core_valid & ~r_core_valid_q;

    always_comb begin
        w_next       = r_state;
        w_abort_code = 2'd0;
        w_beat       = 1'b0;
        w_result     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_stop) w_next = S_ARM;
            end
            S_ARM: begin
                if (i_stop) begin
                    w_next = S_IDLE;
                end else if (i_pix_valid && i_pix_sof) begin
                    w_beat = 1'b1;
                    w_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (!i_pix_valid) begin
                    w_next       = S_ABORT;
                    w_abort_code = 2'd1;
                end else if (i_pix_sof) begin
                    w_next       = S_ABORT;
                    w_abort_code = 2'd2;
                end else begin
                    w_beat = 1'b1;
                    if (r_pix_cnt == PIX_W'(NPIX - 1)) w_next = S_WAIT_RES;
                end
            end
            S_WAIT_RES: begin
                // A result arriving on the last allowed cycle still counts.
                if (w_core_rise) begin
                    w_result = 1'b1;
                    w_next   = S_RELEASE;
                end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                    w_next       = S_ABORT;
                    w_abort_code = 2'd3;
                end
            end
            S_RELEASE: begin
                if (!i_core_valid) w_next = (r_cont && !w_stop_any) ? S_ARM : S_IDLE;
            end
            S_ABORT: begin
                if (r_hold == RST_W'(1)) w_next = (r_cont && !w_stop_any) ? S_ARM : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase

        // Core reset hold: reloaded on entry to ABORT, otherwise drains to zero.
        if (w_abort_code != 2'd0)  w_hold_next = RST_W'(RST_CYC);
        else if (r_hold != '0)     w_hold_next = r_hold - RST_W'(1);
        else                       w_hold_next = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_pix_cnt      <= '0;
            r_timer        <= '0;
            r_hold         <= RST_W'(RST_CYC);
            r_core_rst_n   <= 1'b0;
            r_core_valid   <= 1'b0;
            r_core_valid_q <= 1'b0;
            r_d1           <= 1'b0;
            r_seq          <= 1'b0;
            r_cont         <= 1'b0;
            r_stop_pend    <= 1'b0;
            r_count        <= '0;
            r_count_valid  <= 1'b0;
            r_err          <= 1'b0;
            r_err_code     <= 2'd0;
            r_frame_cnt    <= '0;
        end else begin
            r_state        <= w_next;
            r_hold         <= w_hold_next;
            r_core_rst_n   <= (w_hold_next == '0);
            r_core_valid   <= (w_next == S_STREAM) || (w_next == S_WAIT_RES);
            r_core_valid_q <= i_core_valid;
            r_d1           <= w_beat & i_pix_bin;
            r_seq          <= r_d1;

            if (r_state == S_ARM)  r_pix_cnt <= PIX_W'(1);
            else if (w_beat)       r_pix_cnt <= r_pix_cnt + PIX_W'(1);

            // Timer reads 1 in the first WAIT_RES cycle: cycles elapsed since the last pixel.
            if (r_state == S_WAIT_RES) r_timer <= r_timer + TMR_W'(1);
            else                       r_timer <= TMR_W'(1);

            if (r_state == S_IDLE && i_start && !i_stop) r_cont <= i_cont;

            if (w_next == S_IDLE || w_next == S_ARM) r_stop_pend <= 1'b0;
            else if (i_stop)                         r_stop_pend <= 1'b1;

            r_count_valid <= w_result;
            if (w_result) begin
                r_count     <= i_core_count;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end

            r_err <= (w_abort_code != 2'd0);
            if (w_abort_code != 2'd0) r_err_code <= w_abort_code;
        end
    end

    assign o_core_rst_n  = r_core_rst_n;
    assign o_core_valid  = r_core_valid;
    assign o_core_seq    = r_seq;
    assign o_count       = r_count;
    assign o_count_valid = r_count_valid;
    assign o_busy        = (r_state != S_IDLE);
    assign o_err         = r_err;
    assign o_err_code    = r_err_code;
    assign o_frame_cnt   = r_frame_cnt;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_blob_frame_sequencer.sv
// Self-checking bench for blob_frame_sequencer on a reduced 16x8 frame.
// Pixel and count scoreboards are fed by the drivers and drained by negedge monitors.
module tb_blob_frame_sequencer;
  localparam int IMG_COL = 16;
  localparam int IMG_ROW = 8;
  localparam int NPIX    = IMG_COL * IMG_ROW;
  localparam int TIMEOUT = 64;
  localparam int RST_CYC = 4;
  localparam int CNT_W   = 8;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_start = 1'b0, i_cont = 1'b0, i_stop = 1'b0;
  logic             i_pix_valid = 1'b0, i_pix_sof = 1'b0, i_pix_bin = 1'b0;
  logic             i_core_valid = 1'b0;
  logic [CNT_W-1:0] i_core_count = '0;
  logic             o_core_rst_n, o_core_valid, o_core_seq;
  logic [CNT_W-1:0] o_count;
  logic             o_count_valid, o_busy, o_err;
  logic [1:0]       o_err_code;
  logic [15:0]      o_frame_cnt;
  logic [2:0]       o_dbg_state;

  blob_frame_sequencer #(
    .IMG_COL(IMG_COL), .IMG_ROW(IMG_ROW), .TIMEOUT(TIMEOUT),
    .RST_CYC(RST_CYC), .CNT_W(CNT_W)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_cont(i_cont), .i_stop(i_stop),
    .i_pix_valid(i_pix_valid), .i_pix_sof(i_pix_sof), .i_pix_bin(i_pix_bin),
    .o_core_rst_n(o_core_rst_n), .o_core_valid(o_core_valid), .o_core_seq(o_core_seq),
    .i_core_valid(i_core_valid), .i_core_count(i_core_count),
    .o_count(o_count), .o_count_valid(o_count_valid), .o_busy(o_busy),
    .o_err(o_err), .o_err_code(o_err_code), .o_frame_cnt(o_frame_cnt),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset block
  always #5 i_clk = ~i_clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // scoreboard state
  logic [CNT_W-1:0] exp_q[$];
  logic [0:0]       pix_q[$];
  logic             tb_beat = 1'b0, beat_d1 = 1'b0, beat_d2 = 1'b0;
  int               cv_pulses = 0, err_cnt = 0, err_cyc = 0;
  int               sof_cyc = 0, last_cyc = 0, valid_rise_cyc = -1;
  int               rst_run = 0, last_run = 0;
  logic             prev_cv = 1'b0, busy_watch = 1'b0, busy_drop = 1'b0;
  logic [15:0]      exp_frames = '0;
  logic [CNT_W-1:0] exp_last = '0;

  always @(posedge i_clk) begin
    beat_d1 <= tb_beat;
    beat_d2 <= beat_d1;
  end

  // Monitors: pixel stream, count results, error pulses, core reset runs.
  always @(negedge i_clk) begin
    logic [0:0]       ep;
    logic [CNT_W-1:0] ec;
    if (beat_d2) begin
      checks++;
      if (pix_q.size() == 0) begin
        errors++;
        $display("FAIL pix_seq: unexpected pixel slot at cycle %0d", cyc);
      end else begin
        ep = pix_q.pop_front();
        if (o_core_seq !== ep[0]) begin
          errors++;
          $display("FAIL pix_seq: cycle %0d got %0b want %0b", cyc, o_core_seq, ep[0]);
        end
      end
    end
    if (o_count_valid) begin
      cv_pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL count: unexpected o_count_valid, o_count=%0d", o_count);
      end else begin
        ec = exp_q.pop_front();
        if (o_count !== ec) begin
          errors++;
          $display("FAIL count: got %0d want %0d", o_count, ec);
        end
      end
    end
    if (o_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (o_core_valid && !prev_cv) valid_rise_cyc = cyc;
    prev_cv = o_core_valid;
    if (!o_core_rst_n) rst_run++;
    else if (rst_run != 0) begin
      last_run = rst_run;
      rst_run = 0;
    end
    if (busy_watch && !o_busy) busy_drop = 1'b1;
  end

  // driver tasks
  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic start_cmd(input logic cont);
    tick(); i_start = 1'b1; i_cont = cont;
    tick(); i_start = 1'b0; i_cont = 1'b0;
  endtask

  // kind 0: good frame, 1: valid gap at pos, 2: stray SOF at pos; stop_at<0 means no stop.
  task automatic send_frame(input int kind, input int pos, input int stop_at);
    logic b;
    for (int k = 0; k < 3; k++) begin
      tick(); i_pix_valid = 1'b1; i_pix_sof = 1'b0; i_pix_bin = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < NPIX; i++) begin
      tick();
      i_stop = (i == stop_at);
      b = 1'($urandom_range(0, 1));
      i_pix_bin = b;
      if (kind == 1 && i == pos) begin
        i_pix_valid = 1'b0; i_pix_sof = 1'b0; tb_beat = 1'b0;
        break;
      end else if (kind == 2 && i == pos) begin
        i_pix_valid = 1'b1; i_pix_sof = 1'b1; tb_beat = 1'b0;
        break;
      end
      i_pix_valid = 1'b1;
      i_pix_sof = (i == 0);
      tb_beat = 1'b1;
      pix_q.push_back(b);
      if (i == 0) sof_cyc = cyc;
      if (i == NPIX - 1) last_cyc = cyc;
    end
    tick();
    i_pix_valid = 1'b0; i_pix_sof = 1'b0; i_pix_bin = 1'b0; i_stop = 1'b0; tb_beat = 1'b0;
  endtask

  task automatic core_reply(input int delay, input logic [CNT_W-1:0] value);
    int n;
    repeat (delay) tick();
    i_core_count = value;
    i_core_valid = 1'b1;
    exp_q.push_back(value);
    exp_frames = exp_frames + 16'd1;
    exp_last = value;
    n = 0;
    @(negedge i_clk);
    while (o_core_valid && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    checks++;
    if (o_core_valid) begin
      errors++;
      $display("FAIL release: o_core_valid still %0b after result", o_core_valid);
    end
    tick();
    i_core_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (o_busy && n < max) begin
      @(negedge i_clk);
      n++;
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: o_busy=%0b after %0d cycles, want 0", o_busy, max);
    end
  endtask

  // tests
  task automatic test_reset();
    repeat (3) tick();
    @(negedge i_clk);
    checks++;
    if ({o_core_rst_n, o_core_valid, o_core_seq, o_count, o_count_valid, o_busy,
         o_err, o_err_code, o_frame_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_vals: outputs not all zero (busy=%0b cv=%0b)", o_busy, o_core_valid);
    end
    tick(); i_rst_n = 1'b1;
    for (int k = 0; k < RST_CYC; k++) begin
      @(negedge i_clk);
      checks++;
      if (o_core_rst_n !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: cycle %0d o_core_rst_n=%0b want 0", k, o_core_rst_n);
      end
    end
    @(negedge i_clk);
    checks++;
    if (o_core_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: o_core_rst_n=%0b want 1", o_core_rst_n);
    end
  endtask

  task automatic test_single();
    start_cmd(1'b0);
    send_frame(0, 0, -1);
    core_reply(40, 8'd17);
    wait_idle(50);
    checks++;
    if (valid_rise_cyc !== sof_cyc + 1) begin
      errors++;
      $display("FAIL valid_lead: rise at %0d want %0d", valid_rise_cyc, sof_cyc + 1);
    end
    checks++;
    if (o_count !== 8'd17) begin
      errors++;
      $display("FAIL single_count: got %0d want 17", o_count);
    end
    checks++;
    if (cv_pulses !== 1) begin
      errors++;
      $display("FAIL single_pulses: got %0d want 1", cv_pulses);
    end
    checks++;
    if (o_frame_cnt !== exp_frames) begin
      errors++;
      $display("FAIL single_frames: got %0d want %0d", o_frame_cnt, exp_frames);
    end
    checks++;
    if (o_core_seq !== 1'b0 || o_core_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_quiet: seq=%0b valid=%0b want 0 0", o_core_seq, o_core_valid);
    end
  endtask

  task automatic test_continuous();
    int p0 = cv_pulses;
    start_cmd(1'b1);
    busy_drop = 1'b0;
    busy_watch = 1'b1;
    send_frame(0, 0, -1);
    core_reply(30, 8'd5);
    send_frame(0, 0, -1);
    core_reply(30, 8'd9);
    send_frame(0, 0, 60);
    core_reply(30, 8'd2);
    busy_watch = 1'b0;
    wait_idle(20);
    checks++;
    if (busy_drop !== 1'b0) begin
      errors++;
      $display("FAIL cont_busy: o_busy dropped during continuous run");
    end
    checks++;
    if (cv_pulses - p0 !== 3) begin
      errors++;
      $display("FAIL cont_pulses: got %0d want 3", cv_pulses - p0);
    end
    checks++;
    if (o_count !== 8'd2 || o_frame_cnt !== exp_frames) begin
      errors++;
      $display("FAIL cont_state: count=%0d frames=%0d want 2 %0d", o_count, o_frame_cnt, exp_frames);
    end
  endtask

  task automatic test_gap();
    int e0 = err_cnt;
    start_cmd(1'b1);
    send_frame(1, 100, -1);
    repeat (RST_CYC + 6) tick();
    checks++;
    if (err_cnt - e0 !== 1 || o_err_code !== 2'd1) begin
      errors++;
      $display("FAIL gap_err: pulses=%0d code=%0d want 1 1", err_cnt - e0, o_err_code);
    end
    checks++;
    if (last_run !== RST_CYC) begin
      errors++;
      $display("FAIL gap_core_rst: low for %0d cycles want %0d", last_run, RST_CYC);
    end
    checks++;
    if (o_count !== exp_last || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL gap_rearm: count=%0d busy=%0b want %0d 1", o_count, o_busy, exp_last);
    end
    send_frame(0, 0, NPIX - 1);
    core_reply(20, 8'd33);
    wait_idle(20);
    checks++;
    if (o_count !== 8'd33 || o_frame_cnt !== exp_frames) begin
      errors++;
      $display("FAIL gap_recover: count=%0d frames=%0d want 33 %0d", o_count, o_frame_cnt, exp_frames);
    end
  endtask

  task automatic test_early_sof();
    int e0 = err_cnt;
    start_cmd(1'b0);
    send_frame(2, 50, -1);
    repeat (RST_CYC + 6) tick();
    checks++;
    if (err_cnt - e0 !== 1 || o_err_code !== 2'd2) begin
      errors++;
      $display("FAIL sof_err: pulses=%0d code=%0d want 1 2", err_cnt - e0, o_err_code);
    end
    checks++;
    if (last_run !== RST_CYC || o_busy !== 1'b0 || o_count !== exp_last) begin
      errors++;
      $display("FAIL sof_after: run=%0d busy=%0b count=%0d want %0d 0 %0d",
               last_run, o_busy, o_count, RST_CYC, exp_last);
    end
  endtask

  task automatic test_timeout();
    int e0 = err_cnt;
    int n = 0;
    start_cmd(1'b0);
    send_frame(0, 0, -1);
    while (err_cnt == e0 && n < TIMEOUT + 20) begin
      @(negedge i_clk);
      n++;
    end
    checks++;
    if (err_cnt == e0) begin
      errors++;
      $display("FAIL timeout_seen: no o_err within %0d cycles", TIMEOUT + 20);
    end else if (err_cyc - last_cyc !== TIMEOUT || o_err_code !== 2'd3) begin
      errors++;
      $display("FAIL timeout_err: delay=%0d code=%0d want %0d 3", err_cyc - last_cyc, o_err_code, TIMEOUT);
    end
    wait_idle(RST_CYC + 4);
    checks++;
    if (o_frame_cnt !== exp_frames || o_count !== exp_last) begin
      errors++;
      $display("FAIL timeout_after: frames=%0d count=%0d want %0d %0d",
               o_frame_cnt, o_count, exp_frames, exp_last);
    end
  endtask

  task automatic test_start_stop();
    tick(); i_start = 1'b1; i_stop = 1'b1; i_cont = 1'b1;
    tick(); i_start = 1'b0; i_stop = 1'b0; i_cont = 1'b0;
    repeat (3) tick();
    checks++;
    if (o_busy !== 1'b0 || o_dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL start_stop: busy=%0b state=%0d want 0 0", o_busy, o_dbg_state);
    end
  endtask

  task automatic test_reset_mid();
    start_cmd(1'b1);
    for (int i = 0; i < 20; i++) begin
      tick(); i_pix_valid = 1'b1; i_pix_sof = (i == 0); i_pix_bin = 1'($urandom_range(0, 1));
    end
    i_rst_n = 1'b0;
    i_pix_valid = 1'b0; i_pix_sof = 1'b0;
    #1;
    checks++;
    if ({o_core_rst_n, o_core_valid, o_core_seq, o_count, o_count_valid, o_busy,
         o_err, o_err_code, o_frame_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%0b cv=%0b crst=%0b frames=%0d want all 0",
               o_busy, o_core_valid, o_core_rst_n, o_frame_cnt);
    end
    repeat (2) tick();
    i_rst_n = 1'b1;
    for (int k = 0; k < RST_CYC; k++) begin
      @(negedge i_clk);
      checks++;
      if (o_core_rst_n !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_hold: cycle %0d o_core_rst_n=%0b want 0", k, o_core_rst_n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_continuous();
    test_gap();
    test_early_sof();
    test_timeout();
    test_start_stop();
    test_reset_mid();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0 || pix_q.size() != 0) begin
      errors++;
      $display("FAIL drain: exp_q=%0d pix_q=%0d left, want 0 0", exp_q.size(), pix_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
